// File: rtl/imem_access_arbiter.sv
// Shares the instruction bank's single port between fetch and loader.
// The loader owns the bank during BOOT; in RUN, fetch has priority, but a loader denied MAX_WAIT times in a row is then forced a grant.
module imem_access_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Boot_Done,
  output logic          In_Boot,
  input  logic          F_Req,
  input  logic [AW-1:0] F_Addr,
  output logic          F_Gnt,
  output logic [DW-1:0] F_Data,
  output logic          F_Valid,
  input  logic          L_Req,
  input  logic          L_Wen,
  input  logic [AW-1:0] L_Addr,
  input  logic [DW-1:0] L_WData,
  output logic          L_Gnt,
  output logic [DW-1:0] L_RData,
  output logic          L_Valid,
  output logic [AW-1:0] M_Addr,
  output logic          M_Wen,
  output logic [DW-1:0] M_WData,
  input  logic [DW-1:0] M_RData
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t     state, state_next;
  logic [3:0] wait_cnt, wait_next;
  logic       f_gnt, l_gnt;

  // Rst gates the grants so that no access, and in particular no write, reaches the bank while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (Rst) begin
      if (state == BOOT) begin
        l_gnt = L_Req;
      end else if (F_Req && L_Req) begin
        if (wait_cnt == 4'(MAX_WAIT)) l_gnt = 1'b1;
        else                          f_gnt = 1'b1;
      end else begin
        f_gnt = F_Req;
        l_gnt = L_Req;
      end
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = 4'd0;
    if (state == BOOT) begin
      if (Boot_Done) state_next = RUN;
    end else if (L_Req && !l_gnt) begin
      wait_next = (wait_cnt == 4'(MAX_WAIT)) ? wait_cnt : wait_cnt + 4'd1;
    end
  end

  assign F_Gnt   = f_gnt;
  assign L_Gnt   = l_gnt;
  assign In_Boot = (state == BOOT);
  assign M_Addr  = f_gnt ? F_Addr : (l_gnt ? L_Addr : '0);
  assign M_Wen   = l_gnt && L_Wen;
  assign M_WData = l_gnt ? L_WData : '0;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= BOOT;
      wait_cnt <= 4'd0;
      F_Valid  <= 1'b0;
      L_Valid  <= 1'b0;
      F_Data   <= '0;
      L_RData  <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      F_Valid  <= f_gnt;
      L_Valid  <= l_gnt && !L_Wen;
      if (f_gnt)           F_Data  <= M_RData;
      if (l_gnt && !L_Wen) L_RData <= M_RData;
    end
  end

endmodule

// File: doc/imem_access_arbiter.md
# imem_access_arbiter

Arbiter and sequencer for the 32-word instruction memory bank. Shares the bank's single address/write-enable port between the fetch stage (read-only) and the program loader (read/write). Holds the bank in a loader-only BOOT phase after reset, then runs fetch-priority arbitration with a bounded-wait guarantee for the loader. Registers read data back to the winning requester with a valid strobe.

## Interface
- AW, 5, address width (32 words)
- DW, 32, data width
- MAX_WAIT, 4, consecutive denied loader cycles before the loader is forced a grant (1..15)

- Clk  in  1  clock, all state on posedge
- Rst  in  1  reset, asynchronous, active-low
- Boot_Done  in  1  loader finished; sampled only in BOOT
- In_Boot  out  1  high while in BOOT
- F_Req  in  1  fetch read request
- F_Addr  in  AW  fetch address
- F_Gnt  out  1  fetch granted this cycle (combinational)
- F_Data  out  DW  registered fetch read data
- F_Valid  out  1  F_Data valid, one-cycle pulse
- L_Req  in  1  loader request
- L_Wen  in  1  loader access is a write
- L_Addr  in  AW  loader address
- L_WData  in  DW  loader write data
- L_Gnt  out  1  loader granted this cycle (combinational)
- L_RData  out  DW  registered loader read data
- L_Valid  out  1  L_RData valid, one-cycle pulse (reads only)
- M_Addr  out  AW  to memory address
- M_Wen  out  1  to memory write enable
- M_WData  out  DW  to memory write data
- M_RData  in  DW  from memory, combinational read of M_Addr

## Operation
- States: BOOT, RUN. Reset -> BOOT. BOOT with Boot_Done=1 at posedge -> RUN. RUN is terminal until reset; Boot_Done ignored in RUN.
- BOOT: F_Gnt=0 always; L_Gnt=L_Req.
- RUN: only F_Req -> F_Gnt; only L_Req -> L_Gnt; both -> F_Gnt, unless Wait_Cnt==MAX_WAIT, then L_Gnt.
- Wait_Cnt (4 bits, internal): +1 at posedge when L_Req=1 and L_Gnt=0; cleared when L_Gnt=1 or L_Req=0; saturates at MAX_WAIT. Counts only in RUN; cleared entering RUN.
- At most one grant per cycle; F_Gnt and L_Gnt never both high.
- Memory drive: F_Gnt -> M_Addr=F_Addr, M_Wen=0. L_Gnt -> M_Addr=L_Addr, M_Wen=L_Wen, M_WData=L_WData. No grant -> M_Addr=0, M_Wen=0, M_WData=0.
- Responses: F_Gnt at cycle N -> F_Data<=M_RData, F_Valid=1 in N+1. L_Gnt with L_Wen=0 at N -> L_RData<=M_RData, L_Valid=1 in N+1. Loader writes get no L_Valid; L_Gnt is the acknowledge. F_Data/L_RData hold last value otherwise.
- Requester must hold Req/Addr/WData stable until sampled with its grant; a denied request is not queued internally.

## Timing
- Reset (Rst=0, async): state=BOOT, In_Boot=1, Wait_Cnt=0, F_Valid=0, L_Valid=0, F_Data=0, L_RData=0; grants and M_Wen forced 0 while Rst=0.
- Reset mid-operation: in-flight response discarded (no Valid pulse after release); a write granted in the reset cycle does not occur.
- Grant latency: 0 cycles (combinational). Read latency: 1 cycle grant-to-Valid.
- Write then read same address: write at posedge N, read granted at N+1 returns new data.
- Loader worst-case wait in RUN under continuous F_Req: MAX_WAIT denied cycles, granted on cycle MAX_WAIT+1.
- Boot_Done and L_Req in same BOOT cycle: loader access completes in that cycle; RUN from next cycle.

## Test plan
- Reset, L_Req writes 0x1111_0000+i to addr i, i=0..31, with F_Req=1 throughout BOOT -> F_Gnt stays 0, 32 writes land, In_Boot=1.
- Pulse Boot_Done, then F_Req addr 5 -> F_Gnt same cycle, next cycle F_Valid=1, F_Data=0x1111_0005.
- RUN, F_Req and L_Req (read addr 9) both held, MAX_WAIT=4 -> F_Gnt cycles 0..3, L_Gnt cycle 4, L_Valid cycle 5 with L_RData=0x1111_0009, F_Gnt resumes cycle 5.
- RUN, loader write 0xDEAD_BEEF to addr 3 at N, fetch addr 3 at N+1 -> F_Data=0xDEAD_BEEF at N+2; no L_Valid for the write.
- Assert Rst=0 the cycle after a fetch grant -> F_Valid never pulses, all outputs at reset values asynchronously, state BOOT.
- Idle RUN (no requests) -> M_Wen=0, M_Addr=0, both Valid low, Wait_Cnt stays 0.
